// File: rtl/ex_stage_top.sv
// MIPS execute stage: MEM/WB forwarding, ALU, multi-cycle MDU with HI/LO, EX->MEM register.
// Optional MADD/MADDU accumulate ops are built when MDU_MADD_EN is defined.
module ex_stage_top #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clr,
    input  logic [31:0] PC_EX,
    input  logic [3:0]  alu_op_EX,
    input  logic [3:0]  md_op_EX,
    input  logic        alu_src_imm_EX,
    input  logic [31:0] imm_EX,
    input  logic [31:0] rsData_EX,
    input  logic [31:0] rtData_EX,
    input  logic [4:0]  addrRs_EX,
    input  logic [4:0]  addrRt_EX,
    input  logic [4:0]  regWriteAddr_EX,
    input  logic [1:0]  Tnew_EX,
    input  logic [4:0]  regaddr_MEM,
    input  logic [4:0]  regaddr_WB,
    input  logic [31:0] regdata_MEM,
    input  logic [31:0] regdata_WB,
    output logic        md_busy,
    output logic [31:0] PC_MEM,
    output logic [31:0] aluOut_MEM,
    output logic [31:0] memWriteData_MEM,
    output logic [31:0] regWriteData_MEM,
    output logic [4:0]  addrRt_MEM,
    output logic [4:0]  regWriteAddr_MEM,
    output logic [1:0]  Tnew_MEM
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,
                           ALU_OR   = 4'd3,  ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,
                           ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7,  ALU_SLL  = 4'd8,
                           ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_LUI  = 4'd11,
                           ALU_SLLV = 4'd12, ALU_SRLV = 4'd13, ALU_SRAV = 4'd14;

    localparam logic [3:0] MD_MULT  = 4'd1, MD_MULTU = 4'd2, MD_DIV  = 4'd3,
                           MD_DIVU  = 4'd4, MD_MFHI  = 4'd5, MD_MFLO = 4'd6,
                           MD_MTHI  = 4'd7, MD_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] MD_MADD = 4'd9, MD_MADDU = 4'd10;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] mem_wdata;
        logic [31:0] reg_wdata;
        logic [4:0]  addr_rt;
        logic [4:0]  reg_waddr;
        logic [1:0]  tnew;
    } ex_mem_t;

    // MEM wins over WB; register 0 is never forwarded.
    function automatic logic [31:0] fwd(input logic [4:0]  addr,
                                        input logic [31:0] rf,
                                        input logic [4:0]  a_mem,
                                        input logic [31:0] d_mem,
                                        input logic [4:0]  a_wb,
                                        input logic [31:0] d_wb);
        if (addr != 5'd0 && addr == a_mem) return d_mem;
        if (addr != 5'd0 && addr == a_wb)  return d_wb;
        return rf;
    endfunction

    logic [31:0] rs_fwd, rt_fwd, op_a, op_b, alu_res;
    logic [4:0]  shamt;

    assign rs_fwd = fwd(addrRs_EX, rsData_EX, regaddr_MEM, regdata_MEM, regaddr_WB, regdata_WB);
    assign rt_fwd = fwd(addrRt_EX, rtData_EX, regaddr_MEM, regdata_MEM, regaddr_WB, regdata_WB);
    assign op_a   = rs_fwd;
    assign op_b   = alu_src_imm_EX ? imm_EX : rt_fwd;
    assign shamt  = imm_EX[10:6];

    always_comb begin
        alu_res = '0;
        case (alu_op_EX)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            ALU_SLTU: alu_res = (op_a < op_b) ? 32'd1 : 32'd0;
            ALU_SLL:  alu_res = rt_fwd << shamt;
            ALU_SRL:  alu_res = rt_fwd >> shamt;
            ALU_SRA:  alu_res = $signed(rt_fwd) >>> shamt;
            ALU_LUI:  alu_res = {imm_EX[15:0], 16'h0000};
            ALU_SLLV: alu_res = rt_fwd << rs_fwd[4:0];
            ALU_SRLV: alu_res = rt_fwd >> rs_fwd[4:0];
            ALU_SRAV: alu_res = $signed(rt_fwd) >>> rs_fwd[4:0];
            default:  alu_res = '0;
        endcase
    end

    // MDU: operands are latched at start, the result is applied when the count runs out.
    logic [31:0]   hi, lo, a_q, b_q;
    logic [CW-1:0] md_cnt;
    logic          busy_reg, md_start;
    logic          dec_mul, dec_div, dec_sgn, dec_madd;
    logic          q_div, q_sgn, q_madd;

    assign busy_reg = (md_cnt != '0);

    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_sgn  = 1'b0;
        dec_madd = 1'b0;
        case (md_op_EX)
            MD_MULT:  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
            MD_MULTU: dec_mul = 1'b1;
            MD_DIV:   begin dec_div = 1'b1; dec_sgn = 1'b1; end
            MD_DIVU:  dec_div = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_madd = 1'b1; end
            MD_MADDU: begin dec_mul = 1'b1; dec_madd = 1'b1; end
`endif
            default:  ;
        endcase
    end

    assign md_start = (dec_mul | dec_div) & ~busy_reg & ~stall & reset;
    assign md_busy  = busy_reg | md_start;

    logic [63:0] ext_a, ext_b, prod, acc;
    logic [31:0] mag_a, mag_b, mag_q, mag_r, quo, rem;

    always_comb begin
        ext_a = q_sgn ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
        ext_b = q_sgn ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
        prod  = ext_a * ext_b;
        acc   = {hi, lo} + prod;
        // Divide magnitudes, then restore signs; this also gives 0x80000000/-1 = 0x80000000.
        mag_a = (q_sgn && a_q[31]) ? -a_q : a_q;
        mag_b = (q_sgn && b_q[31]) ? -b_q : b_q;
        mag_q = (mag_b == '0) ? '0 : mag_a / mag_b;
        mag_r = (mag_b == '0) ? '0 : mag_a % mag_b;
        quo   = (q_sgn && (a_q[31] ^ b_q[31])) ? -mag_q : mag_q;
        rem   = (q_sgn && a_q[31]) ? -mag_r : mag_r;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            md_cnt <= '0;
            a_q    <= '0;
            b_q    <= '0;
            q_div  <= 1'b0;
            q_sgn  <= 1'b0;
            q_madd <= 1'b0;
        end else begin
            if (!stall && md_op_EX == MD_MTHI) hi <= rs_fwd;
            if (!stall && md_op_EX == MD_MTLO) lo <= rs_fwd;
            if (md_start) begin
                md_cnt <= dec_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                a_q    <= op_a;
                b_q    <= rt_fwd;
                q_div  <= dec_div;
                q_sgn  <= dec_sgn;
                q_madd <= dec_madd;
            end else if (busy_reg) begin
                md_cnt <= md_cnt - CW'(1);
                if (md_cnt == CW'(1)) begin
                    if (q_div) begin
                        // Divide by zero leaves HI/LO untouched.
                        if (b_q != '0) begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end else if (q_madd) begin
                        {hi, lo} <= acc;
                    end else begin
                        {hi, lo} <= prod;
                    end
                end
            end
        end
    end

    // EX->MEM pipeline register
    ex_mem_t ex_mem_d, ex_mem_q;

    always_comb begin
        ex_mem_d           = '0;
        ex_mem_d.pc        = PC_EX;
        ex_mem_d.alu_out   = alu_res;
        ex_mem_d.mem_wdata = rt_fwd;
        ex_mem_d.reg_wdata = (md_op_EX == MD_MFHI) ? hi :
                             (md_op_EX == MD_MFLO) ? lo : alu_res;
        ex_mem_d.addr_rt   = addrRt_EX;
        ex_mem_d.reg_waddr = regWriteAddr_EX;
        ex_mem_d.tnew      = (Tnew_EX >= 2'd1) ? Tnew_EX - 2'd1 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) ex_mem_q <= '0;
        else if (!stall)   ex_mem_q <= ex_mem_d;
    end

    assign PC_MEM           = ex_mem_q.pc;
    assign aluOut_MEM       = ex_mem_q.alu_out;
    assign memWriteData_MEM = ex_mem_q.mem_wdata;
    assign regWriteData_MEM = ex_mem_q.reg_wdata;
    assign addrRt_MEM       = ex_mem_q.addr_rt;
    assign regWriteAddr_MEM = ex_mem_q.reg_waddr;
    assign Tnew_MEM         = ex_mem_q.tnew;

endmodule
